// File: rtl/cmd_intake_if.sv
// Host command / scheduler / read-return signal bundle for cmd_intake_buffer.
// slave = the buffer itself, master = whatever drives it (host + scheduler + datapath).
interface cmd_intake_if #(
    parameter int DATA_W = 128
);
    logic [33:0]       command;
    logic              valid;
    logic [DATA_W-1:0] write_data;
    logic [7:0]        ba_cmd_pm;
    logic [33:0]       cmd_out;
    logic [DATA_W-1:0] wdata_out;
    logic              cmd_out_valid;
    logic              cmd_out_ready;
    logic [DATA_W-1:0] rdata_in;
    logic              rdata_in_valid;
    logic [DATA_W-1:0] read_data;
    logic              read_data_valid;
    logic [4:0]        rd_pend;
    logic              err_drop;
    logic              err_unexp;

    modport slave (
        input  command, valid, write_data, cmd_out_ready, rdata_in, rdata_in_valid,
        output ba_cmd_pm, cmd_out, wdata_out, cmd_out_valid, read_data, read_data_valid,
               rd_pend, err_drop, err_unexp
    );

    modport master (
        output command, valid, write_data, cmd_out_ready, rdata_in, rdata_in_valid,
        input  ba_cmd_pm, cmd_out, wdata_out, cmd_out_valid, read_data, read_data_valid,
               rd_pend, err_drop, err_unexp
    );
endinterface

// File: rtl/cmd_intake_buffer.sv
// Host command ingress: per-bank paced show-ahead command FIFO, read-return
// register and outstanding-read accounting.
module cmd_intake_buffer #(
    parameter int DEPTH    = 8,
    parameter int BANK_MAX = 4,
    parameter int RD_MAX   = 16,
    parameter int DATA_W   = 128
) (
    input  logic        clk,
    input  logic        power_on_rst,
    cmd_intake_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [33:0]       cmd_mem [DEPTH];
    logic [DATA_W-1:0] wd_mem  [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic [AW:0]       bank_cnt [4];
    logic [4:0]        rd_pend_q;
    logic [DATA_W-1:0] read_data_q;
    logic              read_data_valid_q;
    logic              err_drop_q, err_unexp_q;

    logic [7:0] pm;
    logic [2:0] in_bank;
    logic [1:0] head_bank;
    logic       accept, pop, rd_acc, rd_ret, fifo_ne;

    always_comb begin
        pm = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            pm[b] = (count < (AW+1)'(DEPTH)) && (bank_cnt[b] < (AW+1)'(BANK_MAX))
                    && (rd_pend_q < 5'(RD_MAX));
        end
        in_bank   = bus.command[2:0];
        fifo_ne   = (count != '0);
        head_bank = cmd_mem[rd_ptr][1:0];
        accept    = bus.valid && pm[in_bank];
        pop       = fifo_ne && bus.cmd_out_ready;
        rd_acc    = accept && bus.command[31];
        rd_ret    = bus.rdata_in_valid;
    end

    // Storage is not reset; head outputs are gated to 0 while empty instead.
    always_ff @(posedge clk) begin
        if (accept) begin
            cmd_mem[wr_ptr] <= bus.command;
            wd_mem[wr_ptr]  <= bus.command[31] ? '0 : bus.write_data;
        end
    end

    always_ff @(posedge clk or posedge power_on_rst) begin
        if (power_on_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned b = 0; b < 4; b++) bank_cnt[b] <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            if (accept && !pop)      count <= count + 1'b1;
            else if (pop && !accept) count <= count - 1'b1;
            for (int unsigned b = 0; b < 4; b++) begin
                if ((accept && in_bank[1:0] == 2'(b)) && !(pop && head_bank == 2'(b)))
                    bank_cnt[b] <= bank_cnt[b] + 1'b1;
                else if ((pop && head_bank == 2'(b)) && !(accept && in_bank[1:0] == 2'(b)))
                    bank_cnt[b] <= bank_cnt[b] - 1'b1;
            end
        end
    end

    // A return coinciding with a read accept is treated as matched, not unexpected.
    always_ff @(posedge clk or posedge power_on_rst) begin
        if (power_on_rst) begin
            rd_pend_q         <= '0;
            read_data_q       <= '0;
            read_data_valid_q <= 1'b0;
            err_drop_q        <= 1'b0;
            err_unexp_q       <= 1'b0;
        end else begin
            read_data_valid_q <= rd_ret;
            if (rd_ret) read_data_q <= bus.rdata_in;
            if (bus.valid && !accept) err_drop_q <= 1'b1;
            if (rd_ret && rd_pend_q == '0 && !rd_acc) err_unexp_q <= 1'b1;
            if (rd_acc && !rd_ret)
                rd_pend_q <= rd_pend_q + 1'b1;
            else if (rd_ret && !rd_acc && rd_pend_q != '0)
                rd_pend_q <= rd_pend_q - 1'b1;
        end
    end

    always_comb begin
        bus.ba_cmd_pm       = pm;
        bus.cmd_out_valid   = fifo_ne;
        bus.cmd_out         = fifo_ne ? cmd_mem[rd_ptr] : '0;
        bus.wdata_out       = fifo_ne ? wd_mem[rd_ptr] : '0;
        bus.read_data       = read_data_q;
        bus.read_data_valid = read_data_valid_q;
        bus.rd_pend         = rd_pend_q;
        bus.err_drop        = err_drop_q;
        bus.err_unexp       = err_unexp_q;
    end
endmodule

// File: tb/tb_cmd_intake_buffer.sv
// Self-checking bench for cmd_intake_buffer: command scoreboard, read-sequence
// vector table and hand-written pacing / saturation / reset sequences.
module tb_cmd_intake_buffer;
    localparam int DEPTH = 8, BANK_MAX = 4, RD_MAX = 16, DATA_W = 128;

    logic clk = 1'b0;
    logic power_on_rst = 1'b1;
    always #5 clk = ~clk;

    cmd_intake_if #(.DATA_W(DATA_W)) dif ();

    cmd_intake_buffer #(
        .DEPTH(DEPTH), .BANK_MAX(BANK_MAX), .RD_MAX(RD_MAX), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .power_on_rst(power_on_rst), .bus(dif.slave)
    );

    typedef struct {
        logic [33:0]       c;
        logic [DATA_W-1:0] w;
    } ent_t;

    typedef struct {
        logic [33:0]       cmd;
        logic              v;
        logic [DATA_W-1:0] wd;
        logic              rdy;
        logic              rv;
        logic [DATA_W-1:0] rd;
        logic              exp_cov;
        logic [4:0]        exp_rdpend;
        logic              exp_rdv;
    } vec_t;

    int total = 0;
    int bad = 0;

    ent_t sbq[$];
    int   m_count;
    int   m_bank[4];
    int   m_rd;
    bit   m_drop, m_unexp;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [33:0] mk(input bit rw, input logic [2:0] bank, input logic [9:0] col);
        return {2'b00, rw, 1'b0, 13'd0, 1'b0, 1'b0, 1'b0, 1'b0, col, bank};
    endfunction

    function automatic logic [7:0] model_pm();
        logic [7:0] p = '0;
        for (int b = 0; b < 4; b++)
            p[b] = (m_count < DEPTH) && (m_bank[b] < BANK_MAX) && (m_rd < RD_MAX);
        return p;
    endfunction

    task automatic model_reset();
        sbq.delete();
        m_count = 0;
        for (int b = 0; b < 4; b++) m_bank[b] = 0;
        m_rd = 0;
        m_drop = 0;
        m_unexp = 0;
    endtask

    // One clock: drive at posedge+1, predict, check head against scoreboard, then
    // check registered outputs at the next posedge+1.
    task automatic step(input logic [33:0] c, input logic v, input logic [DATA_W-1:0] wd,
                        input logic rdy, input logic rv, input logic [DATA_W-1:0] rd);
        logic [7:0] p;
        logic acc, pop;
        ent_t e;
        dif.command = c; dif.valid = v; dif.write_data = wd;
        dif.cmd_out_ready = rdy; dif.rdata_in_valid = rv; dif.rdata_in = rd;
        p = model_pm();
        #1;
        check("pm", {120'd0, dif.ba_cmd_pm}, {120'd0, p});
        check("cmd_out_valid", {127'd0, dif.cmd_out_valid}, {127'd0, (m_count != 0)});
        acc = v && p[c[2:0]];
        pop = (m_count != 0) && rdy;
        if (rv && m_rd == 0 && !(acc && c[31])) m_unexp = 1;
        if (pop) begin
            if (sbq.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                e = sbq.pop_front();
                check("cmd_out", {94'd0, dif.cmd_out}, {94'd0, e.c});
                check("wdata_out", dif.wdata_out, e.w);
                m_bank[e.c[1:0]]--;
                m_count--;
            end
        end
        if (acc) begin
            e.c = c;
            e.w = c[31] ? '0 : wd;
            sbq.push_back(e);
            m_bank[c[1:0]]++;
            m_count++;
        end
        if (v && !acc) m_drop = 1;
        if (acc && c[31] && !rv) m_rd++;
        else if (rv && !(acc && c[31]) && m_rd > 0) m_rd--;
        @(posedge clk); #1;
        check("read_data_valid", {127'd0, dif.read_data_valid}, {127'd0, rv});
        if (rv) check("read_data", dif.read_data, rd);
        check("rd_pend", {123'd0, dif.rd_pend}, 128'(m_rd));
        check("err_drop", {127'd0, dif.err_drop}, {127'd0, m_drop});
        check("err_unexp", {127'd0, dif.err_unexp}, {127'd0, m_unexp});
    endtask

    task automatic idle(input logic rdy);
        step('0, 1'b0, '0, rdy, 1'b0, '0);
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH; i++) begin
            if (m_count == 0) break;
            idle(1'b1);
        end
        check("drain_empty", {127'd0, dif.cmd_out_valid}, 128'd0);
    endtask

    vec_t vt[4];
    logic [DATA_W-1:0] beef;

    initial begin
        beef = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
        dif.command = '0; dif.valid = 0; dif.write_data = '0; dif.cmd_out_ready = 0;
        dif.rdata_in = '0; dif.rdata_in_valid = 0;
        model_reset();

        vt[0] = '{34'h2_8004_0408, 1'b1, 128'hFFFF_0000_FFFF, 1'b0, 1'b0, '0,   1'b1, 5'd1, 1'b0};
        vt[1] = '{34'h0,           1'b0, '0,                  1'b1, 1'b0, '0,   1'b0, 5'd1, 1'b0};
        vt[2] = '{34'h0,           1'b0, '0,                  1'b0, 1'b1, beef, 1'b0, 5'd0, 1'b1};
        vt[3] = '{34'h0,           1'b0, '0,                  1'b0, 1'b0, '0,   1'b0, 5'd0, 1'b0};

        // reset state
        repeat (2) @(posedge clk);
        #1 power_on_rst = 1'b0;
        #1;
        check("rst_pm", {120'd0, dif.ba_cmd_pm}, 128'h0F);
        check("rst_cmd_out", {94'd0, dif.cmd_out}, 128'd0);
        check("rst_read_data", dif.read_data, 128'd0);
        check("rst_flags", {121'd0, dif.cmd_out_valid, dif.read_data_valid, dif.rd_pend},
              128'd0);
        @(posedge clk); #1;
        idle(1'b0);

        // bank pacing: 4 writes to bank 0 accepted, rest dropped
        for (int i = 0; i < 8; i++) begin
            step(mk(0, 3'd0, 10'(i)), 1'b1, {$urandom, $urandom, $urandom, $urandom},
                 1'b0, 1'b0, '0);
            if (i == 3) check("pm_bank0_full", {120'd0, dif.ba_cmd_pm}, 128'h0E);
            if (i == 4) check("err_drop_set", {127'd0, dif.err_drop}, 128'd1);
        end
        drain();

        // fill the shared FIFO across banks, pop one
        for (int i = 0; i < DEPTH; i++)
            step(mk(0, 3'(i % 4), 10'(16 + i)), 1'b1, {4{$urandom}}, 1'b0, 1'b0, '0);
        check("pm_fifo_full", {120'd0, dif.ba_cmd_pm}, 128'h00);
        idle(1'b1);
        check("pm_after_pop", {120'd0, dif.ba_cmd_pm}, 128'h0F);
        drain();

        // read command then its return, table-driven
        for (int i = 0; i < 4; i++) begin
            step(vt[i].cmd, vt[i].v, vt[i].wd, vt[i].rdy, vt[i].rv, vt[i].rd);
            check($sformatf("vec%0d_cov", i), {127'd0, dif.cmd_out_valid}, {127'd0, vt[i].exp_cov});
            check($sformatf("vec%0d_rdpend", i), {123'd0, dif.rd_pend}, {123'd0, vt[i].exp_rdpend});
            check($sformatf("vec%0d_rdv", i), {127'd0, dif.read_data_valid}, {127'd0, vt[i].exp_rdv});
        end

        // outstanding-read saturation
        for (int i = 0; i < RD_MAX; i++)
            step(mk(1, 3'(i % 4), 10'(i)), 1'b1, {4{$urandom}}, 1'b1, 1'b0, '0);
        check("rd_pend_max", {123'd0, dif.rd_pend}, 128'd16);
        check("pm_rd_full", {120'd0, dif.ba_cmd_pm}, 128'h00);
        drain();
        step('0, 1'b0, '0, 1'b0, 1'b1, {4{$urandom}});
        check("rd_pend_15", {123'd0, dif.rd_pend}, 128'd15);
        check("pm_rd_restored", {120'd0, dif.ba_cmd_pm}, 128'h0F);
        for (int i = 0; i < RD_MAX - 1; i++)
            step('0, 1'b0, '0, 1'b0, 1'b1, {4{$urandom}});
        check("rd_pend_zero", {123'd0, dif.rd_pend}, 128'd0);

        // unexpected return, then asynchronous reset with FIFO non-empty
        step('0, 1'b0, '0, 1'b0, 1'b1, beef);
        check("err_unexp_set", {127'd0, dif.err_unexp}, 128'd1);
        step(mk(0, 3'd1, 10'd5), 1'b1, {4{$urandom}}, 1'b0, 1'b0, '0);
        step(mk(1, 3'd2, 10'd6), 1'b1, '0, 1'b0, 1'b0, '0);
        dif.valid = 1'b0;
        #2 power_on_rst = 1'b1;
        #1;
        check("arst_cov", {127'd0, dif.cmd_out_valid}, 128'd0);
        check("arst_state", {120'd0, dif.rd_pend, dif.err_drop, dif.err_unexp, dif.read_data_valid},
              128'd0);
        check("arst_pm", {120'd0, dif.ba_cmd_pm}, 128'h0F);
        model_reset();
        #2 power_on_rst = 1'b0;
        @(posedge clk); #1;
        step(mk(0, 3'd3, 10'd9), 1'b1, {4{$urandom}}, 1'b0, 1'b0, '0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
